// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: slave end of the vscale dmem two-phase port, backed by a word SRAM array.
// Latency: RESP comes 1+WAIT_CYCLES cycles after accept (1 for a flagged access); rdata is combinational in RESP.
// Backpressure: dmem_wait high through the wait states, new requests ignored until RESP.
// Optional macro VSCALE_DMEM_BADMEM_CHECK_EN enables the misalign/size/range checks.
module vscale_dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  // byte-address width covering the whole array
  localparam int         AW        = DEPTH_LOG2 + 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [2:0]      size_q;
  logic            bad_q;
  logic            accept;
  logic            req_bad;
  logic [3:0]      lanes;
  logic            do_write;
  logic [31:0]     mem [0:(1<<DEPTH_LOG2)-1];

  // a request is only refused while wait states are being served
  assign accept = dmem_en && (state != WAIT);

`ifdef VSCALE_DMEM_BADMEM_CHECK_EN
  logic out_of_range;
  logic misaligned;
  logic bad_size;

  // classify the incoming request; loads and stores have different legal size sets
  always_comb begin
    out_of_range = (dmem_addr[31:AW] != '0);
    misaligned   = 1'b0;
    bad_size     = 1'b0;
    if (dmem_wen) begin
      bad_size   = (dmem_size > 3'd2);
      misaligned = ((dmem_size == 3'd1) && dmem_addr[0]) ||
                   ((dmem_size == 3'd2) && (dmem_addr[1:0] != 2'b00));
    end else begin
      bad_size   = (dmem_size == 3'd3) || (dmem_size == 3'd6) || (dmem_size == 3'd7);
      misaligned = (((dmem_size == 3'd1) || (dmem_size == 3'd5)) && dmem_addr[0]) ||
                   ((dmem_size == 3'd2) && (dmem_addr[1:0] != 2'b00));
    end
    req_bad = out_of_range || misaligned || bad_size;
  end
`else
  // without checking, upper address bits are dropped so accesses wrap around the array
  logic unused_addr_hi;
  assign unused_addr_hi = ^dmem_addr[31:AW];
  assign req_bad        = 1'b0;
`endif

  // next-state: flagged accesses and zero-wait configs go straight to RESP
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      default: begin
        if (accept) begin
          if ((WAIT_CYCLES == 0) || req_bad) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // state, counter and latched request; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      wen_q  <= 1'b0;
      size_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= dmem_addr[AW-1:0];
        wen_q  <= dmem_wen;
        size_q <= dmem_size;
        bad_q  <= req_bad;
      end
    end
  end

  // byte lanes of a store; unknown sizes fall back to a full word
  always_comb begin
    lanes = 4'b1111;
    if (size_q == 3'd0) begin
      lanes = 4'b0001 << addr_q[1:0];
    end else if (size_q == 3'd1) begin
      lanes = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  // the write lands on the edge closing RESP, so a following load's RESP sees it
  assign do_write = (state == RESP) && wen_q && !bad_q && !reset;

  // SRAM array write; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) begin
          mem[addr_q[AW-1:2]][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
        end
      end
    end
  end

  assign dmem_wait     = (state == WAIT);
  assign dmem_badmem_e = (state == RESP) && bad_q;
  assign dmem_rdata    = ((state == RESP) && !bad_q) ? mem[addr_q[AW-1:2]] : 32'h0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 3 and 4 wait states) share one stimulus stream.
// A timeline reference model predicts every output of every instance; directed table and sequences add fixed expectations.
`timescale 1ns/1ps
module tb_vscale_dmem_responder;

  localparam int D  = 10;
  localparam int NI = 3;
`ifdef VSCALE_DMEM_BADMEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wen;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata [NI];
  logic        wt    [NI];
  logic        bad   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 4;
    vscale_dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(WC)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .dmem_en            (en),
      .dmem_wen           (wen),
      .dmem_size          (size),
      .dmem_addr          (addr),
      .dmem_wdata_delayed (wdata),
      .dmem_rdata         (rdata[g]),
      .dmem_wait          (wt[g]),
      .dmem_badmem_e      (bad[g])
    );
  end

  // reference model state
  logic [31:0] mm    [NI][1<<D];
  bit          known [NI][1<<D];
  bit          m_pend [NI];
  logic [31:0] m_addr [NI];
  bit          m_wen  [NI];
  logic [2:0]  m_size [NI];
  bit          m_bad  [NI];
  int          m_resp [NI];
  int          tcyc;
  int          tests;
  int          fails;

  function automatic int wcyc(int g);
    return (g == 0) ? 0 : (g == 1) ? 3 : 4;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a / 32'd4) % 32'(1 << D));
  endfunction

  function automatic bit is_bad(bit w, logic [2:0] s, logic [31:0] a);
    bit b;
    longint unsigned ad;
    b  = 1'b0;
    ad = longint'(a);
    if (!CHK) return 1'b0;
    if (ad >= (64'd4 << D)) b = 1'b1;
    if (w) begin
      if (s > 3'd2) b = 1'b1;
      if (s == 3'd1 && a[0]) b = 1'b1;
      if (s == 3'd2 && a[1:0] != 2'b00) b = 1'b1;
    end else begin
      if (s == 3'd3 || s == 3'd6 || s == 3'd7) b = 1'b1;
      if ((s == 3'd1 || s == 3'd5) && a[0]) b = 1'b1;
      if (s == 3'd2 && a[1:0] != 2'b00) b = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [3:0] lane_mask(logic [2:0] s, logic [31:0] a);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic check(string name, int g, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %h, want %h", name, g, tcyc, act, exp);
    end
  endtask

  // drive one cycle, advance the model past the edge, compare all instances
  task automatic step(bit r, bit e, bit w, logic [2:0] s, logic [31:0] a, logic [31:0] d);
    bit prev_resp, prev_wait, in_resp;
    int wi;
    logic [3:0] ln;
    reset = r; en = e; wen = w; size = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
    tcyc++;
    for (int g = 0; g < NI; g++) begin
      prev_resp = m_pend[g] && (m_resp[g] == tcyc - 1);
      prev_wait = m_pend[g] && (m_resp[g] > tcyc - 1);
      if (r) begin
        m_pend[g] = 1'b0;
      end else begin
        if (prev_resp) begin
          if (m_wen[g] && !m_bad[g]) begin
            wi = widx(m_addr[g]);
            ln = lane_mask(m_size[g], m_addr[g]);
            for (int b = 0; b < 4; b++)
              if (ln[b]) mm[g][wi][8*b +: 8] = d[8*b +: 8];
            if (ln == 4'hF) known[g][wi] = 1'b1;
          end
          m_pend[g] = 1'b0;
        end
        if (e && !prev_wait) begin
          m_pend[g] = 1'b1;
          m_addr[g] = a;
          m_wen[g]  = w;
          m_size[g] = s;
          m_bad[g]  = is_bad(w, s, a);
          m_resp[g] = tcyc + (m_bad[g] ? 0 : wcyc(g));
        end
      end
      in_resp = m_pend[g] && (tcyc == m_resp[g]);
      check("wait", g, 32'(wt[g]), 32'(m_pend[g] && (tcyc < m_resp[g])));
      check("badmem", g, 32'(bad[g]), 32'(in_resp && m_bad[g]));
      if (in_resp && !m_bad[g]) begin
        wi = widx(m_addr[g]);
        if (known[g][wi]) check("rdata", g, rdata[g], mm[g][wi]);
      end else begin
        check("rdata", g, rdata[g], 32'h0);
      end
    end
  endtask

  task automatic idle(int n, logic [31:0] d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, d);
  endtask

  function automatic logic [31:0] pre(int w);
    return (w == 12) ? 32'h11223344 : 32'h10000000 + 32'(w) * 32'h01010101;
  endfunction

  typedef struct {
    bit          en;
    bit          wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          wt;
    bit          bd;
  } vec_t;

  function automatic vec_t mk(bit e, bit w, logic [2:0] s, logic [31:0] a, logic [31:0] d,
                              logic [31:0] rd, bit bd);
    vec_t v;
    v.en = e; v.wen = w; v.size = s; v.addr = a; v.wdata = d;
    v.rd = rd; v.wt = 1'b0; v.bd = bd;
    return v;
  endfunction

  initial begin
    vec_t tbl [12];
    logic [31:0] ra;
    tests = 0;
    fails = 0;
    tcyc  = 0;

    // rows: store data rides one slot behind its address; expectations are for the zero-wait instance
    tbl[0]  = mk(1, 1, 3'd2, 32'h10, 32'h0,        32'h14040404, 0);
    tbl[1]  = mk(1, 0, 3'd2, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 0, 3'd0, 32'h0,  32'h0,        32'h0,        0);
    tbl[3]  = mk(1, 1, 3'd0, 32'h31, 32'h0,        32'h11223344, 0);
    tbl[4]  = mk(1, 1, 3'd1, 32'h32, 32'hAAAAAAAA, 32'h1122AA44, 0);
    tbl[5]  = mk(1, 0, 3'd2, 32'h30, 32'hBBBBBBBB, 32'hBBBBAA44, 0);
    tbl[6]  = mk(0, 0, 3'd0, 32'h0,  32'h0,        32'h0,        0);
    tbl[7]  = mk(1, 0, 3'd2, 32'h22, 32'h0,        CHK ? 32'h0 : 32'h18080808, CHK);
    tbl[8]  = mk(1, 1, 3'd1, 32'h33, 32'h0,        CHK ? 32'h0 : 32'hBBBBAA44, CHK);
    tbl[9]  = mk(1, 0, 3'd2, 32'h1000, 32'hCCCCCCCC, CHK ? 32'h0 : 32'h10000000, CHK);
    tbl[10] = mk(1, 0, 3'd2, 32'h30, 32'h0,        CHK ? 32'hBBBBAA44 : 32'hCCCCAA44, 0);
    tbl[11] = mk(0, 0, 3'd0, 32'h0,  32'h0,        32'h0,        0);

    // reset state
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int g = 0; g < NI; g++) begin
      check("reset_rdata", g, rdata[g], 32'h0);
      check("reset_wait", g, 32'(wt[g]), 32'h0);
      check("reset_badmem", g, 32'(bad[g]), 32'h0);
    end

    // preload words 0..31, paced for the slowest instance
    for (int w = 0; w < 32; w++) begin
      step(1'b0, 1'b1, 1'b1, 3'd2, 32'(w * 4), 32'h0);
      idle(5, pre(w));
    end

    // directed table on the zero-wait instance
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].en, tbl[i].wen, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      check($sformatf("tbl%0d_rdata", i), 0, rdata[0], tbl[i].rd);
      check($sformatf("tbl%0d_wait", i), 0, 32'(wt[0]), 32'(tbl[i].wt));
      check($sformatf("tbl%0d_badmem", i), 0, 32'(bad[0]), 32'(tbl[i].bd));
    end
    idle(6, 32'h0);

    // three wait states: LW 0x20, a request mid-wait must be ignored
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    check("w3_wait_c6", 1, 32'(wt[1]), 32'h1);
    check("w3_rdata_c6", 1, rdata[1], 32'h0);
    idle(1, 32'h0);
    check("w3_wait_c7", 1, 32'(wt[1]), 32'h1);
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check("w3_wait_c8", 1, 32'(wt[1]), 32'h1);
    idle(1, 32'h0);
    check("w3_wait_c9", 1, 32'(wt[1]), 32'h0);
    check("w3_rdata_c9", 1, rdata[1], 32'h18080808);
    idle(1, 32'h0);
    check("w3_ignored_wait", 1, 32'(wt[1]), 32'h0);
    check("w3_ignored_rdata", 1, rdata[1], 32'h0);
    idle(6, 32'h0);

    // four wait states: reset in the second wait cycle of SW 0x40 abandons the store
    step(1'b0, 1'b1, 1'b1, 3'd2, 32'h40, 32'h55555555);
    check("w4_wait1", 2, 32'(wt[2]), 32'h1);
    idle(1, 32'h55555555);
    check("w4_wait2", 2, 32'(wt[2]), 32'h1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h55555555);
    check("w4_rst_wait", 2, 32'(wt[2]), 32'h0);
    check("w4_rst_rdata", 2, rdata[2], 32'h0);
    check("w4_rst_badmem", 2, 32'(bad[2]), 32'h0);
    idle(2, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
    idle(4, 32'h0);
    check("w4_old_word", 2, rdata[2], 32'h20101010);
    idle(6, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        ra = (32'($urandom_range(0, 255)) << 12) | 32'($urandom_range(0, 127));
      else
        ra = 32'($urandom_range(0, 127));
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ra, $urandom);
    end
    idle(6, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_responder.md
# vscale_dmem_responder

Data-memory responder for the vscale core's dmem port: the slave end of the two-phase protocol the pipeline control drives with `dmem_en`/`dmem_wen`/`dmem_size` and consumes as `dmem_wait`/`dmem_badmem_e`. It accepts an address phase in the core's DX cycle and completes the data phase in WB. The data phase can be stretched by a configurable number of wait states, and illegal accesses are flagged. The block backs a word-organised SRAM array and is used as on-chip data RAM and as the testbench memory model.

## Interface
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words, byte addresses 0 to 4·2^DEPTH_LOG2−1.
- `WAIT_CYCLES`, default 0: wait states per legal access, range 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `dmem_en` in 1: address-phase request.
- `dmem_wen` in 1: request is a store.
- `dmem_size` in 3: RV32 funct3 of the load or store.
- `dmem_addr` in 32: byte address, valid in the address phase.
- `dmem_wdata_delayed` in 32: store data, already lane-positioned by the core, valid throughout the data phase.
- `dmem_rdata` out 32: aligned word containing the addressed bytes; the core extracts and extends.
- `dmem_wait` out 1: data phase not finished; the core stalls WB.
- `dmem_badmem_e` out 1: access error, valid on the final data-phase cycle.

## Operation
- State register: IDLE, WAIT, RESP.
- Accept rule: an address phase is accepted when `dmem_en`=1 and state≠WAIT. On acceptance the block latches addr, wen, size and bad.
- Transition on acceptance:
  - To RESP if WAIT_CYCLES=0 or the access is bad.
  - Otherwise to WAIT, with the counter loaded to WAIT_CYCLES.
- WAIT:
  - `dmem_wait`=1.
  - Counter decrements each cycle; when it is 1, the next state is RESP.
  - `dmem_en` is ignored in WAIT.
- RESP:
  - `dmem_wait`=0.
  - `dmem_rdata` = array[latched addr[DEPTH_LOG2+1:2]], read combinationally.
  - A legal store writes the enabled lanes at the closing edge.
  - Next state: IDLE, or a new accept if `dmem_en`=1. Back-to-back accesses therefore run at one per cycle when WAIT_CYCLES=0.
- Store lanes:
  - size 0 (SB): lane addr[1:0].
  - size 1 (SH): lanes {addr[1],0} and {addr[1],1}.
  - size 2 (SW): all four lanes.
  - Other lanes keep their old value.
- Bad access (only under the macro, see Configuration):
  - SH or LH/LHU with addr[0]=1.
  - SW or LW with addr[1:0]≠0.
  - Load size 3, 6 or 7.
  - Store size greater than 2.
  - addr ≥ 4·2^DEPTH_LOG2.
- Bad access response:
  - `dmem_badmem_e`=1 for exactly the RESP cycle.
  - No array write.
  - `dmem_rdata`=0.
- Outside RESP, `dmem_rdata`=0 and `dmem_badmem_e`=0.

## Timing
- Reset values: state IDLE, counter 0, `dmem_wait`=0, `dmem_badmem_e`=0, `dmem_rdata`=0. Latched request fields are cleared. Array contents are not cleared.
- Reset during WAIT or RESP abandons the access. A store that has not reached its RESP edge is not written.
- Latency: accept at cycle N, RESP at cycle N+1+WAIT_CYCLES (N+1 for a bad access).
- `dmem_wait` is high on cycles N+1 through N+WAIT_CYCLES.
- `dmem_wait` and `dmem_badmem_e` are decoded from registered state only; there is no combinational path from any input.
- Store then load to the same word on back-to-back cycles: the load's RESP sees the new data, because the write lands at the store RESP edge before the load reads.
- `dmem_wdata_delayed` is sampled only at the RESP edge; its value during WAIT is don't-care.

## Configuration
- `VSCALE_DMEM_BADMEM_CHECK_EN` defined: misalignment, illegal-size and range checks are active as described above.
- `VSCALE_DMEM_BADMEM_CHECK_EN` undefined:
  - `dmem_badmem_e` is tied to 0.
  - Addresses wrap modulo the array size.
  - Misaligned accesses use addr[1:0] as given: lanes for SH come from addr[1] only, SW writes all lanes.
  - Illegal sizes behave as SW or LW.

## Test plan
- Reset, WAIT_CYCLES=0: SW 0xDEADBEEF to 0x10, then LW 0x10 back-to-back. Required: `dmem_wait` never asserts, and `dmem_rdata`=0xDEADBEEF in the load's RESP cycle.
- WAIT_CYCLES=3: LW 0x20 accepted at cycle 5. Required: `dmem_wait`=1 on cycles 6–8 and 0 at cycle 9 with valid data; a `dmem_en` pulse at cycle 7 is ignored.
- Word 0x30 preset to 0x11223344: SB with wdata 0xAAAAAAAA to 0x31, then SH with wdata 0xBBBBBBBB to 0x32. Required: reading word 0x30 returns 0xBBBBAA44.
- Macro on: LW 0x22, then SH 0x33, then LW 0x4·2^DEPTH_LOG2. Required: each gives `dmem_badmem_e`=1 for one cycle with no wait states, and memory is unchanged.
- Macro off, same three accesses. Required: `dmem_badmem_e` stays 0; the out-of-range LW returns word 0.
- WAIT_CYCLES=4: assert `reset` during the second wait cycle of an SW to 0x40. Required: outputs are 0 on the next cycle, and word 0x40 holds its old value.
